fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// buffering with PC tagging, and redirect flush of in-flight responses.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter int unsigned          FIFO_DEPTH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_ImemReq,
    output logic [WORD_SIZE-1:0] o_ImemAddr,
    input  logic                 i_ImemReady,
    input  logic                 i_ImemValid,
    input  logic [WORD_SIZE-1:0] i_ImemRdata,
    output logic                 o_Valid,
    output logic [WORD_SIZE-1:0] o_Instruction,
    output logic [WORD_SIZE-1:0] o_Pc,
    input  logic                 i_Ready,
    input  logic                 i_Redirect,
    input  logic [WORD_SIZE-1:0] i_RedirectPc,
    output logic                 o_Error
);

    localparam int unsigned          PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned          CW      = PW + 1;
    localparam logic [CW:0]          DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] ALIGN_M = ~WORD_SIZE'(3);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]          outst_q, outst_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   error_q, error_d;
    logic [WORD_SIZE-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   fifo_instr_d [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   fifo_pc_d    [FIFO_DEPTH];

    logic                   redirect;
    logic [WORD_SIZE-1:0]   redirect_pc;
    logic [CW:0]            credit_used;
    logic                   imem_req;
    logic                   req_xfer;
    logic                   resp_ok;
    logic                   spurious;
    logic                   push;
    logic                   pop;
    logic                   valid;

    // Handshake decode; BOOT ignores redirect entirely.
    always_comb begin
        redirect    = i_Redirect && (state_q != ST_BOOT);
        redirect_pc = i_RedirectPc & ALIGN_M;
        credit_used = {1'b0, outst_q} + {1'b0, count_q};
        imem_req    = (state_q == ST_FETCH) && !i_Redirect && (credit_used < DEPTH_C);
        req_xfer    = imem_req && i_ImemReady;
        resp_ok     = i_ImemValid && (outst_q != '0);
        spurious    = i_ImemValid && (outst_q == '0);
        push        = resp_ok && (state_q == ST_FETCH) && !redirect;
        valid       = (count_q != '0);
        pop         = valid && i_Ready && !redirect;
    end

    always_comb begin
        outst_d  = outst_q + CW'(req_xfer) - CW'(resp_ok);
        error_d  = error_q | spurious;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end else begin
            if (req_xfer) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (push)     resp_pc_d  = resp_pc_q + PC_STEP;
        end

        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        if (push) begin
            fifo_instr_d[wr_ptr_q] = i_ImemRdata;
            fifo_pc_d[wr_ptr_q]    = resp_pc_q;
        end

        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end

        // Flush lasts until every request issued before the redirect has answered.
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH, ST_FLUSH: begin
                if (redirect) begin
                    state_d = (outst_d != '0) ? ST_FLUSH : ST_FETCH;
                end else if ((state_q == ST_FLUSH) && (outst_d == '0)) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_VECTOR;
            resp_pc_q    <= RESET_VECTOR;
            outst_q      <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            error_q      <= 1'b0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            error_q      <= error_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    assign o_ImemReq     = imem_req;
    assign o_ImemAddr    = fetch_pc_q;
    assign o_Valid       = valid;
    assign o_Instruction = valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign o_Pc          = valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign o_Error       = error_q;

endmodule
